// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback, drives datapath enables, and tracks retired and illegal instructions.
//
// state     | meaning
// ----------+-----------------------------------------------
// FETCH     | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE    | read registers, precompute branch target
// MEM_ADDR  | ALU computes A + sign-extended offset
// MEM_READ  | load data from ALUOut address, waits on mem_ready
// MEM_WB    | write MDR to rt
// MEM_WRITE | store B to ALUOut address, waits on mem_ready
// R_EXEC    | ALU operates on A, B under Funct
// R_WB      | write ALUOut to rd
// BRANCH    | A - B, PC <= target if Zero
// JUMP      | PC <= jump target
// I_EXEC    | ALU operates on A and immediate
// I_WB      | write ALUOut to rt
module multicycle_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           Op,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 PCWriteCond,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 MemtoReg,
    output logic                 IRWrite,
    output logic [1:0]           PCSource,
    output logic [1:0]           ALUOp,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic                 RegWrite,
    output logic                 RegDst,
    output logic [3:0]           state,
    output logic                 illegal_op,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        I_EXEC    = 4'd10,
        I_WB      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t cur;

    assign state = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= FETCH;
            illegal_op <= 1'b0;
            retired    <= '0;
        end else begin
            illegal_op <= 1'b0;
            case (cur)
                FETCH:     if (mem_ready) cur <= DECODE;
                DECODE: begin
                    case (Op)
                        OP_RTYPE:       cur <= R_EXEC;
                        OP_LW, OP_SW:   cur <= MEM_ADDR;
                        OP_BEQ:         cur <= BRANCH;
                        OP_J:           cur <= JUMP;
                        OP_ADDI, OP_ANDI: cur <= I_EXEC;
                        default: begin
                            cur        <= FETCH;
                            illegal_op <= 1'b1;
                        end
                    endcase
                end
                MEM_ADDR:  cur <= (Op == OP_LW) ? MEM_READ : MEM_WRITE;
                MEM_READ:  if (mem_ready) cur <= MEM_WB;
                MEM_WRITE: begin
                    if (mem_ready) begin
                        cur     <= FETCH;
                        retired <= retired + CNT_ONE;
                    end
                end
                R_EXEC:    cur <= R_WB;
                I_EXEC:    cur <= I_WB;
                MEM_WB, R_WB, BRANCH, JUMP, I_WB: begin
                    cur     <= FETCH;
                    retired <= retired + CNT_ONE;
                end
                default:   cur <= FETCH;
            endcase
        end
    end

    // Control decode; anything not set for a state stays 0, including unused codes.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        case (cur)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = mem_ready;
                IRWrite = mem_ready;
            end
            DECODE:    ALUSrcB = 2'b11;
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b11;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (Op == OP_ANDI) ? 2'b01 : 2'b00;
            end
            I_WB:      RegWrite = 1'b1;
            default: ;
        endcase
    end

endmodule
